// File: rtl/tetris_ctrl.sv
// tetris_ctrl: turns buttons, gravity and garbage requests into single-cycle core commands.
// Optional LEFT/RIGHT/DOWN autorepeat is compiled in by defining TETRIS_CTRL_AUTOREPEAT_EN.
package enum_type;
  typedef enum logic [3:0] {
    NONE, INIT, WAIT, LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD, BAR, END
  } state_type;
endpackage

module tetris_ctrl
  import enum_type::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GRAVITY_BASE = 50_000_000,
  parameter int unsigned GRAVITY_STEP = 4_000_000,
  parameter int unsigned GRAVITY_MIN  = 5_000_000,
  parameter int unsigned REPEAT_DELAY = 10_000_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  btn,
  input  logic        start,
  input  logic        bar_req,
  input  logic [31:0] rng,
  input  state_type   state,
  input  logic [15:0] score,
  output state_type   ctrl,
  output logic [9:0]  bar_mask,
  output logic [3:0]  level,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  // Pending-flag index equals btn bit index; index 7 is BAR. Listed highest priority first.
  localparam logic [2:0] PRIO [8] = '{3'd6, 3'd2, 3'd3, 3'd0, 3'd1, 3'd5, 3'd4, 3'd7};

  function automatic state_type srcCmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return LEFT;
      3'd1:    return RIGHT;
      3'd2:    return ROTATE;
      3'd3:    return ROTATE_REV;
      3'd4:    return DOWN;
      3'd5:    return DROP;
      3'd6:    return HOLD;
      default: return BAR;
    endcase
  endfunction

  function automatic logic [31:0] periodFor(input logic [3:0] lvl);
    logic [31:0] red, raw;
    red = 32'(lvl) * GRAVITY_STEP;
    raw = (red >= GRAVITY_BASE) ? 32'd0 : GRAVITY_BASE - red;
    return (raw > GRAVITY_MIN) ? raw : GRAVITY_MIN;
  endfunction

  logic [6:0]  r_btnQ;
  logic        r_startQ;
  logic [7:0]  r_pend;
  logic [9:0]  r_barPend;
  logic [AW:0] r_wrPtr, r_rdPtr;
  state_type   r_fifoCmd [FIFO_DEPTH];
  logic [9:0]  r_fifoMask [FIFO_DEPTH];
  state_type   r_ctrl;
  logic [9:0]  r_barMask;
  logic [3:0]  r_level;
  logic [7:0]  r_dropCnt;
  logic [31:0] r_gravCnt, r_period;

  logic        w_active, w_startRise, w_gravEvt, w_empty, w_full, w_pop, w_push, w_canWrite;
  logic [6:0]  w_btnEvt, w_repEvt;
  logic [7:0]  w_evt, w_grant;
  logic [3:0]  w_col, w_dropInc;
  logic [8:0]  w_dropSum;
  state_type   w_pushCmd;
  logic [9:0]  w_pushMask;

`ifdef TETRIS_CTRL_AUTOREPEAT_EN
  // One repeat timer follows the lowest-index held button of LEFT, RIGHT, DOWN.
  logic [1:0]  w_repSel, r_repSel;
  logic [31:0] r_repCnt;
  logic        r_repArmed, w_repFire;

  always_comb begin
    w_repSel = 2'd0;
    if (btn[0])      w_repSel = 2'd1;
    else if (btn[1]) w_repSel = 2'd2;
    else if (btn[4]) w_repSel = 2'd3;
  end

  assign w_repFire = (w_repSel == r_repSel) && (r_repSel != 2'd0) &&
                     (r_repCnt == (r_repArmed ? (REPEAT_RATE - 1) : (REPEAT_DELAY - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_repSel   <= 2'd0;
      r_repCnt   <= 32'd0;
      r_repArmed <= 1'b0;
    end else if (w_repSel != r_repSel) begin
      r_repSel   <= w_repSel;
      r_repCnt   <= 32'd0;
      r_repArmed <= 1'b0;
    end else if (r_repSel != 2'd0) begin
      r_repCnt   <= w_repFire ? 32'd0 : r_repCnt + 32'd1;
      r_repArmed <= r_repArmed | w_repFire;
    end
  end

  always_comb begin
    w_repEvt = '0;
    case (r_repSel)
      2'd1:    w_repEvt[0] = w_repFire;
      2'd2:    w_repEvt[1] = w_repFire;
      2'd3:    w_repEvt[4] = w_repFire;
      default: w_repEvt = '0;
    endcase
  end

  logic w_unusedBits;
  assign w_unusedBits = ^{rng[31:4], score[3:0]};
`else
  logic w_unusedBits;
  assign w_repEvt     = '0;
  assign w_unusedBits = ^{rng[31:4], score[3:0], 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  assign w_active    = (state != INIT) && (state != END);
  assign w_startRise = start & ~r_startQ;
  assign w_btnEvt    = (btn & ~r_btnQ) | w_repEvt;
  assign w_gravEvt   = w_active && (r_gravCnt == r_period - 32'd1);
  assign w_col       = (rng[3:0] >= 4'd10) ? rng[3:0] - 4'd10 : rng[3:0];

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = (state == WAIT) && !w_empty && (r_ctrl == NONE);

  // Events are ignored while the core is idle in INIT/END, so nothing is counted as merged.
  always_comb begin
    w_evt    = {bar_req, w_btnEvt};
    w_evt[4] = w_evt[4] | w_gravEvt;
    if (!w_active) w_evt = '0;
  end

  always_comb begin
    w_grant    = '0;
    w_pushCmd  = NONE;
    w_canWrite = w_active && (!w_full || w_pop);
    for (int p = 0; p < 8; p++) begin
      if (w_canWrite && (w_grant == '0) && r_pend[PRIO[p]]) begin
        w_grant[PRIO[p]] = 1'b1;
        w_pushCmd        = srcCmd(PRIO[p]);
      end
    end
    w_push     = |w_grant;
    w_pushMask = w_grant[7] ? r_barPend : 10'd0;
  end

  // A button DOWN edge coinciding with a gravity tick is two events on one flag.
  always_comb begin
    w_dropInc = {3'd0, w_btnEvt[4] & w_gravEvt & w_active};
    for (int i = 0; i < 8; i++) begin
      if (w_evt[i] && r_pend[i] && !w_grant[i]) w_dropInc = w_dropInc + 4'd1;
    end
    w_dropSum = {1'b0, r_dropCnt} + {5'd0, w_dropInc};
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoCmd[r_wrPtr[AW-1:0]]  <= w_pushCmd;
      r_fifoMask[r_wrPtr[AW-1:0]] <= w_pushMask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btnQ    <= '0;
      r_startQ  <= 1'b0;
      r_pend    <= '0;
      r_barPend <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_ctrl    <= NONE;
      r_barMask <= '0;
      r_level   <= 4'd0;
      r_dropCnt <= 8'd0;
      r_gravCnt <= 32'd0;
      r_period  <= periodFor(4'd0);
    end else begin
      r_btnQ    <= btn;
      r_startQ  <= start;
      r_level   <= (score[15:8] == 8'd0) ? score[7:4] : 4'd9;
      r_dropCnt <= w_dropSum[8] ? 8'hFF : w_dropSum[7:0];
      if (!w_active) begin
        r_pend    <= '0;
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
        r_gravCnt <= 32'd0;
        r_period  <= periodFor(r_level);
        r_ctrl    <= w_startRise ? WAIT : NONE;
      end else begin
        r_pend <= (r_pend & ~w_grant) | w_evt;
        if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + PTR_ONE;
          r_ctrl  <= r_fifoCmd[r_rdPtr[AW-1:0]];
          if (r_fifoCmd[r_rdPtr[AW-1:0]] == BAR) r_barMask <= r_fifoMask[r_rdPtr[AW-1:0]];
        end else begin
          r_ctrl <= NONE;
        end
        // A new level's period is only picked up at a wrap.
        if (w_gravEvt) begin
          r_gravCnt <= 32'd0;
          r_period  <= periodFor(r_level);
        end else begin
          r_gravCnt <= r_gravCnt + 32'd1;
        end
        if (bar_req) r_barPend <= 10'd1 << w_col;
      end
    end
  end

  assign ctrl     = r_ctrl;
  assign bar_mask = r_barMask;
  assign level    = r_level;
  assign drop_cnt = r_dropCnt;
endmodule

// File: tb/tb_tetris_ctrl.sv
// tb_tetris_ctrl: vector tables, directed core-handshake sequences and a randomized run
// compared cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_tetris_ctrl;
  import enum_type::*;

  localparam int DEPTH = 4;
  localparam int GBASE = 100;
  localparam int GSTEP = 10;
  localparam int GMIN  = 30;

  typedef struct {
    logic [31:0] stim;
    logic [9:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  btn;
  logic        start, bar_req;
  logic [31:0] rng;
  state_type   state;
  logic [15:0] score;
  state_type   ctrl;
  logic [9:0]  bar_mask;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  state_type issued[$];
  int        issuedAt[$];

  state_type   srcCmd [8] = '{LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD, BAR};
  int          prioSrc [8] = '{6, 2, 3, 0, 1, 5, 4, 7};
  logic [15:0] scoreVals [6] = '{16'h0000, 16'h0012, 16'h0050, 16'h0090, 16'h0100, 16'h0345};

  // Reference model state
  logic [6:0]  mBtnQ;
  logic        mStartQ;
  bit          mPend [8];
  logic [9:0]  mBarPend;
  state_type   mQCmd[$];
  logic [9:0]  mQMask[$];
  state_type   mCtrl;
  logic [9:0]  mBarMask;
  logic [3:0]  mLevel;
  int          mDrop, mGrav, mPeriod;

  tetris_ctrl #(
    .FIFO_DEPTH(DEPTH), .GRAVITY_BASE(GBASE), .GRAVITY_STEP(GSTEP), .GRAVITY_MIN(GMIN),
    .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .start(start), .bar_req(bar_req), .rng(rng),
    .state(state), .score(score), .ctrl(ctrl), .bar_mask(bar_mask), .level(level),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1; btn = '0; start = 1'b0; bar_req = 1'b0; rng = '0; state = INIT; score = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Core stand-in: leaves WAIT for 3 cycles after every token it receives.
  task automatic runCore(input int nCycles);
    int busy = 0;
    issued.delete();
    issuedAt.delete();
    state = WAIT;
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      if (ctrl != NONE) begin
        issued.push_back(ctrl);
        issuedAt.push_back(cycle);
        busy = 3;
      end
      if (busy > 0) begin
        state = BAR;
        busy--;
      end else begin
        state = WAIT;
      end
    end
    state = WAIT;
  endtask

  function automatic int gapAt(input int i);
    if (i + 1 < issuedAt.size()) return issuedAt[i+1] - issuedAt[i];
    return -1;
  endfunction

  function automatic state_type issuedOr(input int i);
    return (i < issued.size()) ? issued[i] : NONE;
  endfunction

  function automatic int periodOf(input int lvl);
    int p;
    p = GBASE - lvl * GSTEP;
    if (p < GMIN) p = GMIN;
    return p;
  endfunction

  task automatic modelReset();
    mBtnQ = '0; mStartQ = 1'b0; mBarPend = '0; mCtrl = NONE; mBarMask = '0; mLevel = '0;
    mDrop = 0; mGrav = 0; mPeriod = periodOf(0);
    foreach (mPend[i]) mPend[i] = 1'b0;
    mQCmd.delete();
    mQMask.delete();
  endtask

  // Advances the model across one rising edge using the currently driven inputs.
  task automatic modelStep();
    logic [6:0]  rise;
    logic [9:0]  hm;
    state_type   nCtrl;
    int          cnt [8];
    int          g;
    bit          pop, gEv, was;
    rise  = btn & ~mBtnQ;
    nCtrl = NONE;
    if (state == INIT || state == END) begin
      if (start && !mStartQ) nCtrl = WAIT;
      foreach (mPend[i]) mPend[i] = 1'b0;
      mQCmd.delete();
      mQMask.delete();
      mGrav   = 0;
      mPeriod = periodOf(int'(mLevel));
    end else begin
      pop = (state == WAIT) && (mQCmd.size() > 0) && (mCtrl == NONE);
      gEv = (mGrav == mPeriod - 1);
      g = -1;
      if (mQCmd.size() < DEPTH || pop)
        for (int p = 0; p < 8; p++) if (g < 0 && mPend[prioSrc[p]]) g = prioSrc[p];
      if (pop) begin
        nCtrl = mQCmd.pop_front();
        hm    = mQMask.pop_front();
        if (nCtrl == BAR) mBarMask = hm;
      end
      if (g >= 0) begin
        mQCmd.push_back(srcCmd[g]);
        mQMask.push_back((g == 7) ? mBarPend : 10'd0);
      end
      for (int i = 0; i < 7; i++) cnt[i] = int'(rise[i]);
      cnt[4] += int'(gEv);
      cnt[7] = int'(bar_req);
      for (int i = 0; i < 8; i++) begin
        was = mPend[i] && (g != i);
        if (g == i) mPend[i] = 1'b0;
        if (cnt[i] > 0) begin
          mDrop += was ? cnt[i] : cnt[i] - 1;
          mPend[i] = 1'b1;
        end
      end
      if (mDrop > 255) mDrop = 255;
      if (gEv) begin
        mGrav   = 0;
        mPeriod = periodOf(int'(mLevel));
      end else begin
        mGrav++;
      end
      if (bar_req) mBarPend = 10'd1 << (rng[3:0] % 10);
    end
    mCtrl   = nCtrl;
    mLevel  = (score[15:8] == 8'd0) ? score[7:4] : 4'd9;
    mBtnQ   = btn;
    mStartQ = start;
  endtask

  task automatic applyStimulus();
    int r;
    btn     = btn ^ 7'($urandom & $urandom & $urandom);
    if ($urandom_range(0, 7) == 0) start = ~start;
    bar_req = ($urandom_range(0, 11) == 0);
    rng     = $urandom;
    if ($urandom_range(0, 4) == 0) begin
      r = $urandom_range(0, 19);
      state = (r < 11) ? WAIT : (r < 14) ? BAR : (r < 16) ? LEFT : (r < 18) ? INIT : END;
    end
    if ($urandom_range(0, 99) == 0) score = scoreVals[$urandom_range(0, 5)];
  endtask

  initial begin
    vec_t      levelVec [9];
    vec_t      barVec [6];
    state_type expPrio [3];
    state_type expLat [5];

    levelVec = '{'{32'h0000, 10'd0}, '{32'h0012, 10'd1}, '{32'h0009, 10'd0},
                 '{32'h0050, 10'd5}, '{32'h0080, 10'd8}, '{32'h0099, 10'd9},
                 '{32'h0100, 10'd9}, '{32'h1000, 10'd9}, '{32'h9999, 10'd9}};
    barVec   = '{'{32'd13, 10'b0000001000}, '{32'd0, 10'b0000000001},
                 '{32'd9, 10'b1000000000},  '{32'd10, 10'b0000000001},
                 '{32'd15, 10'b0000100000}, '{32'hABCD0004, 10'b0000010000}};
    expPrio  = '{HOLD, LEFT, RIGHT};
    expLat   = '{NONE, NONE, LEFT, NONE, NONE};

    resetDut();
    checkOutput("reset_ctrl", 32'(ctrl), 32'(NONE));
    checkOutput("reset_bar_mask", 32'(bar_mask), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);

    // Single LEFT press: token on the third edge, for one cycle only.
    state = WAIT;
    btn   = 7'b0000001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("latency[%0d]", i), 32'(ctrl), 32'(expLat[i]));
      if (i == 4) btn = '0;
    end
    checkOutput("latency_drop_cnt", 32'(drop_cnt), 32'd0);

    resetDut();
    btn = 7'b1000011;
    runCore(25);
    btn = '0;
    checkOutput("prio_count", 32'(issued.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("prio_order[%0d]", i), 32'(issuedOr(i)), 32'(expPrio[i]));

    // Six LEFT edges while the core is busy: 4 queued, 1 pending, 1 merged.
    resetDut();
    state = BAR;
    for (int k = 0; k < 6; k++) begin
      btn[0] = 1'b1;
      @(negedge clk);
      btn[0] = 1'b0;
      @(negedge clk);
    end
    checkOutput("fill_drop_cnt", 32'(drop_cnt), 32'd1);
    runCore(40);
    checkOutput("fill_count", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("fill_tok[%0d]", i), 32'(issuedOr(i)), 32'(LEFT));

    resetDut();
    for (int i = 0; i < 6; i++) begin
      state   = WAIT;
      rng     = barVec[i].stim;
      bar_req = 1'b1;
      @(negedge clk);
      bar_req = 1'b0;
      rng     = $urandom;
      runCore(10);
      checkOutput($sformatf("bar_count[%0d]", i), 32'(issued.size()), 32'd1);
      checkOutput($sformatf("bar_tok[%0d]", i), 32'(issuedOr(0)), 32'(BAR));
      checkOutput($sformatf("bar_mask[%0d]", i), 32'(bar_mask), 32'(barVec[i].exp));
    end

    resetDut();
    for (int i = 0; i < 9; i++) begin
      score = levelVec[i].stim[15:0];
      @(negedge clk);
      checkOutput($sformatf("level[%0d]", i), 32'(level), 32'(levelVec[i].exp));
    end

    // Gravity: level 1 gives 90 cycles; level 9 floors at 30 from the following wrap.
    resetDut();
    score = 16'h0012;
    repeat (2) @(negedge clk);
    runCore(300);
    checkOutput("grav_l1_count", 32'(issued.size()), 32'd3);
    checkOutput("grav_l1_tok", 32'(issuedOr(0)), 32'(DOWN));
    checkOutput("grav_l1_gap0", 32'(gapAt(0)), 32'd90);
    checkOutput("grav_l1_gap1", 32'(gapAt(1)), 32'd90);
    score = 16'h0100;
    runCore(160);
    checkOutput("grav_l9_level", 32'(level), 32'd9);
    checkOutput("grav_l9_gap0", 32'(gapAt(0)), 32'd30);
    checkOutput("grav_l9_gap1", 32'(gapAt(1)), 32'd30);

    // END flushes queued work; start edge produces a single WAIT token.
    resetDut();
    state = BAR;
    btn   = 7'b0000011;
    repeat (3) @(negedge clk);
    btn   = '0;
    state = END;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checkOutput("end_start_tok", 32'(ctrl), 32'(WAIT));
    @(negedge clk);
    checkOutput("end_start_clear", 32'(ctrl), 32'(NONE));
    start = 1'b0;
    runCore(20);
    checkOutput("end_no_stale", 32'(issued.size()), 32'd0);

    resetDut();
    modelReset();
    for (int n = 0; n < 2500; n++) begin
      applyStimulus();
      modelStep();
      @(negedge clk);
      checkOutput("rnd_ctrl", 32'(ctrl), 32'(mCtrl));
      checkOutput("rnd_bar_mask", 32'(bar_mask), 32'(mBarMask));
      checkOutput("rnd_level", 32'(level), 32'(mLevel));
      checkOutput("rnd_drop_cnt", 32'(drop_cnt), 32'(mDrop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
